fp_normalize_round: RTL and testbench

- Post-arithmetic stage that sits directly downstream of the floating-point divider and multiplier datapaths.
- Takes an unnormalized sign/exponent/extended-mantissa triple and normalizes it iteratively, one shift per cycle.
- Rounds to nearest-even and packs an IEEE-754 word. Handles subnormal results, overflow to infinity and special-value passthrough.
- Uses valid/ready handshakes on both sides so the divider can stall on it.

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_normalize_round_if.sv | 34 +++
 rtl/fp_round_rne.sv | 28 ++
 rtl/fp_normalize_round.sv | 129 ++++++++++++
 tb/tb_fp_normalize_round.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants and FSM state codes used by the divider,
// multiplier and the normalize/round stage.
package fp_pkg;
   localparam int EXP_WIDTH  = 8;
   localparam int MANT_WIDTH = 23;
   localparam int WIDTH      = 1 + EXP_WIDTH + MANT_WIDTH;
   localparam int BIAS       = (1 << (EXP_WIDTH - 1)) - 1;
   localparam int EXP_MAX    = (1 << EXP_WIDTH) - 1;

   localparam logic [WIDTH-1:0] CANON_NAN =
      {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

   // State codes kept as plain 2-bit constants so older blocks can compare them directly.
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] NORM  = 2'd1;
   localparam logic [1:0] ROUND = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/fp_normalize_round_if.sv
// Upstream/downstream handshake bundle for the normalize/round stage.
interface fp_normalize_round_if #(
   parameter int EXP_WIDTH  = 8,
   parameter int MANT_WIDTH = 23,
   parameter int WIDTH      = 32
);
   // A transfer occurs on a clock edge where valid and ready are both high;
   // valid, once raised, holds its payload stable until that edge, and
   // ready never depends combinationally on valid.
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_sign;
   logic [EXP_WIDTH+1:0]    in_exp;
   logic [MANT_WIDTH+3:0]   in_mant;
   logic                    in_nan;
   logic                    in_inf;
   logic                    in_zero;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        result;
   logic                    out_overflow;
   logic                    out_underflow;
   logic                    out_inexact;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
      input  in_ready, out_valid, result, out_overflow, out_underflow, out_inexact
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
      output in_ready, out_valid, result, out_overflow, out_underflow, out_inexact
   );
endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a normalized (or subnormal) mantissa
// holding hidden, fraction, guard and sticky bits.
module fp_round_rne #(
   parameter int EXP_WIDTH  = 8,
   parameter int MANT_WIDTH = 23
) (
   input  logic [MANT_WIDTH+2:0]        mant,
   input  logic signed [EXP_WIDTH+1:0]  exp_in,
   output logic [MANT_WIDTH-1:0]        frac,
   output logic signed [EXP_WIDTH+1:0]  exp_out,
   output logic                         inexact,
   output logic                         carry
);
   logic lsb, g, s, up;

   always_comb begin
      lsb     = mant[2];
      g       = mant[1];
      s       = mant[0];
      up      = g & (s | lsb);
      inexact = g | s;
      // The fraction wraps to zero on an all-ones carry, which is exactly the
      // renormalized fraction; carry tells the caller the hidden bit was reached.
      frac    = mant[MANT_WIDTH+1:2] + {{(MANT_WIDTH-1){1'b0}}, up};
      carry   = up & (&mant[MANT_WIDTH+1:2]);
      exp_out = exp_in + {{(EXP_WIDTH+1){1'b0}}, carry & mant[MANT_WIDTH+2]};
   end
endmodule

// File: rtl/fp_normalize_round.sv
// Iterative normalize (one shift per cycle), RNE round and IEEE-754 pack stage
// downstream of the FP divider and multiplier.
module fp_normalize_round #(
   parameter int WIDTH      = 32,
   parameter int EXP_WIDTH  = 8,
   parameter int MANT_WIDTH = 23
) (
   input  logic                 clk,
   input  logic                 reset,
   fp_normalize_round_if.slave  bus,
   output logic [1:0]           state_dbg
);
   import fp_pkg::*;

   localparam int EW2 = EXP_WIDTH + 2;
   localparam int MW4 = MANT_WIDTH + 4;
   localparam logic signed [EW2-1:0] EXP_ONE      = EW2'(1);
   localparam logic signed [EW2-1:0] EXP_COLLAPSE = EW2'(-(MANT_WIDTH + 2));
   localparam logic signed [EW2-1:0] EXP_SAT      = EW2'((1 << EXP_WIDTH) - 1);
   localparam logic [WIDTH-1:0] NAN_WORD =
      {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

   logic [1:0]              state;
   logic                    sign_r;
   logic signed [EW2-1:0]   exp_r;
   logic [MW4-1:0]          mant_r;
   logic [WIDTH-1:0]        result_r;
   logic                    ovf_r, unf_r, inex_r;

   logic [MANT_WIDTH-1:0]   r_frac;
   logic signed [EW2-1:0]   r_exp;
   logic                    r_inexact, r_carry;
   logic                    hidden_after, tiny, round_ovf;
   logic [MW4-1:0]          mant_shr;

   fp_round_rne #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_rne (
      .mant    (mant_r[MW4-2:0]),
      .exp_in  (exp_r),
      .frac    (r_frac),
      .exp_out (r_exp),
      .inexact (r_inexact),
      .carry   (r_carry)
   );

   assign mant_shr     = {1'b0, mant_r[MW4-1:2], mant_r[1] | mant_r[0]};
   assign hidden_after = mant_r[MW4-2] | r_carry;
   assign tiny         = ~mant_r[MW4-2] & (exp_r == EXP_ONE);
   assign round_ovf    = (r_exp >= EXP_SAT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sign_r   <= 1'b0;
         exp_r    <= '0;
         mant_r   <= '0;
         result_r <= '0;
         ovf_r    <= 1'b0;
         unf_r    <= 1'b0;
         inex_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               sign_r <= bus.in_sign;
               exp_r  <= bus.in_exp;
               mant_r <= bus.in_mant;
               ovf_r  <= 1'b0;
               unf_r  <= 1'b0;
               inex_r <= 1'b0;
               if (bus.in_nan) begin
                  result_r <= NAN_WORD;
                  state    <= DONE;
               end else if (bus.in_inf) begin
                  result_r <= {bus.in_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                  state    <= DONE;
               end else if (bus.in_zero || bus.in_mant == '0) begin
                  result_r <= {bus.in_sign, {(WIDTH-1){1'b0}}};
                  state    <= DONE;
               end else begin
                  state <= NORM;
               end
            end
            NORM: begin
               if (mant_r[MW4-1]) begin
                  mant_r <= mant_shr;
                  exp_r  <= exp_r + EXP_ONE;
               end else if (exp_r < EXP_COLLAPSE) begin
                  // Far below the subnormal range: only the sticky information survives.
                  mant_r <= {{(MW4-1){1'b0}}, |mant_r};
                  exp_r  <= EXP_ONE;
               end else if (exp_r < EXP_ONE) begin
                  mant_r <= mant_shr;
                  exp_r  <= exp_r + EXP_ONE;
               end else if (!mant_r[MW4-2] && exp_r > EXP_ONE) begin
                  mant_r <= {mant_r[MW4-2:0], 1'b0};
                  exp_r  <= exp_r - EXP_ONE;
               end else begin
                  state <= ROUND;
               end
            end
            ROUND: begin
               if (round_ovf) begin
                  result_r <= {sign_r, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                  ovf_r    <= 1'b1;
                  unf_r    <= 1'b0;
                  inex_r   <= 1'b1;
               end else begin
                  result_r <= {sign_r,
                               hidden_after ? r_exp[EXP_WIDTH-1:0] : {EXP_WIDTH{1'b0}},
                               r_frac};
                  ovf_r    <= 1'b0;
                  unf_r    <= r_inexact & tiny;
                  inex_r   <= r_inexact;
               end
               state <= DONE;
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready      = (state == IDLE);
   assign bus.out_valid     = (state == DONE);
   assign bus.result        = result_r;
   assign bus.out_overflow  = ovf_r;
   assign bus.out_underflow = unf_r;
   assign bus.out_inexact   = inex_r;
   assign state_dbg         = state;
endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed corner cases, backpressure, async reset
// and randomized triples against an exact-arithmetic RNE reference.
module tb_fp_normalize_round;
   import fp_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] state_dbg;
   int         checks = 0;
   int         errors = 0;
   logic [34:0] exp_q[$];

   fp_normalize_round_if #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH), .WIDTH(WIDTH)) bus ();

   fp_normalize_round #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: treat the 27-bit mantissa as the exact value m * 2^(e-BIAS-25)
   // and round it to a float with plain integer arithmetic.
   function automatic logic [34:0] ref_model(input logic s, input int e, input logic [26:0] m,
                                             input logic nan, input logic inf, input logic zero);
      longint sig, rem, half;
      int     p, ef, q, sh, n;
      logic   inex, tiny;
      logic [7:0] field;
      if (nan) return {CANON_NAN, 3'b000};
      if (inf) return {s, 8'hFF, 23'd0, 3'b000};
      if (zero || m == 27'd0) return {s, 31'd0, 3'b000};
      p = 0;
      for (int i = 0; i < 27; i++) if (m[i]) p = i;
      ef   = p + e - 25;
      tiny = (ef < 1);
      q    = tiny ? 1 : ef;
      sh   = e - q - 2;
      if (sh >= 0) begin
         sig  = longint'(m) << sh;
         inex = 1'b0;
      end else begin
         n = -sh;
         if (n > 40) begin
            sig  = 0;
            inex = 1'b1;
         end else begin
            sig  = longint'(m) >> n;
            rem  = longint'(m) & ((longint'(1) << n) - 1);
            half = longint'(1) << (n - 1);
            inex = (rem != 0);
            if (rem > half || (rem == half && sig[0])) sig = sig + 1;
         end
      end
      if (sig >= (longint'(1) << 24)) begin
         sig = sig >> 1;
         q   = q + 1;
      end
      if (q >= EXP_MAX) return {s, 8'hFF, 23'd0, 3'b101};
      field = (sig < (longint'(1) << 23)) ? 8'd0 : q[7:0];
      return {s, field, sig[22:0], 1'b0, tiny & inex, inex};
   endfunction

   // driver: one full transaction, with scoreboard check of the packed word and flags
   task automatic run_txn(input logic s, input int e, input logic [26:0] m,
                          input logic nan, input logic inf, input logic zero,
                          input logic [34:0] expv, input int lat, input string tag);
      int cyc;
      logic [34:0] want;
      @(negedge clk);
      chk({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
      bus.in_sign  = s;
      bus.in_exp   = 10'(e);
      bus.in_mant  = m;
      bus.in_nan   = nan;
      bus.in_inf   = inf;
      bus.in_zero  = zero;
      bus.in_valid = 1'b1;
      exp_q.push_back(expv);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      cyc = 1;
      while (!bus.out_valid && cyc < 200) begin
         chk({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'd0);
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
      if (lat != 0) chk({tag, "_latency"}, 64'(cyc), 64'(lat));
      chk({tag, "_in_ready_done"}, 64'(bus.in_ready), 64'd0);
      want = exp_q.pop_front();
      chk(tag, {29'd0, bus.result, bus.out_overflow, bus.out_underflow, bus.out_inexact},
          {29'd0, want});
      if (bus.out_ready) begin
         @(posedge clk);
         #1;
         chk({tag, "_out_valid_drop"}, 64'(bus.out_valid), 64'd0);
      end
   endtask

   initial begin
      logic [26:0] m;
      logic        s, nan, inf, zero;
      int          e, r, p;

      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_sign = 1'b0;
      bus.in_exp = '0;
      bus.in_mant = '0;
      bus.in_nan = 1'b0;
      bus.in_inf = 1'b0;
      bus.in_zero = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_result", {29'd0, bus.result, bus.out_overflow, bus.out_underflow, bus.out_inexact}, 64'd0);
      chk("rst_state", 64'(state_dbg), 64'(IDLE));
      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_txn(0, BIAS, 27'd1 << 25, 0, 0, 0, {32'h3F800000, 3'b000}, 3, "one");
      run_txn(0, 130, 27'd1 << 22, 0, 0, 0, {32'h3F800000, 3'b000}, 6, "lshift3");
      run_txn(0, 127, (27'd1 << 25) | 27'd6, 0, 0, 0, {32'h3F800002, 3'b001}, 3, "tie_odd");
      run_txn(0, 127, (27'd1 << 25) | 27'd2, 0, 0, 0, {32'h3F800000, 3'b001}, 3, "tie_even");
      run_txn(0, 127, 27'h3FFFFFF, 0, 0, 0, {32'h40000000, 3'b001}, 3, "carry_all");
      run_txn(0, 255, 27'd1 << 25, 0, 0, 0, {32'h7F800000, 3'b101}, 3, "overflow");
      run_txn(0, -1, 27'd1 << 25, 0, 0, 0, {32'h00200000, 3'b000}, 5, "subnorm");
      run_txn(0, -200, 27'd1 << 25, 0, 0, 0, {32'h00000000, 3'b011}, 4, "collapse");
      run_txn(1, 5, 27'd1 << 25, 1, 1, 1, {CANON_NAN, 3'b000}, 1, "nan");
      run_txn(1, 5, 27'd1 << 25, 0, 1, 1, {32'hFF800000, 3'b000}, 1, "inf");
      run_txn(1, 5, 27'd1 << 25, 0, 0, 1, {32'h80000000, 3'b000}, 1, "zero");
      run_txn(1, 50, 27'd0, 0, 0, 0, {32'h80000000, 3'b000}, 1, "mant_zero");

      // backpressure: result must hold while the consumer stalls
      bus.out_ready = 1'b0;
      run_txn(0, 128, (27'd1 << 25) | (27'd1 << 24), 0, 0, 0, {32'h40400000, 3'b000}, 3, "stall");
      repeat (10) begin
         @(posedge clk);
         #1;
         chk("stall_valid", 64'(bus.out_valid), 64'd1);
         chk("stall_result", 64'(bus.result), 64'h40400000);
         chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_release", 64'(bus.out_valid), 64'd0);
      chk("stall_idle", 64'(bus.in_ready), 64'd1);

      // async reset while shifting
      @(negedge clk);
      bus.in_sign = 1'b0;
      bus.in_exp = 10'd130;
      bus.in_mant = 27'd1 << 22;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("rst_mid_norm", 64'(state_dbg), 64'(NORM));
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_mid_result", 64'(bus.result), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
      run_txn(0, BIAS, 27'd1 << 25, 0, 0, 0, {32'h3F800000, 3'b000}, 3, "after_rst");

      // randomized triples against the reference model
      for (int i = 0; i < 150; i++) begin
         r    = int'($urandom_range(0, 19));
         s    = 1'($urandom_range(0, 1));
         nan  = (r == 0);
         inf  = (r == 1) || (r == 0 && $urandom_range(0, 1) == 1);
         zero = (r == 2) || (r < 2 && $urandom_range(0, 1) == 1);
         p    = int'($urandom_range(20, 26));
         m    = (27'($urandom()) & ((27'd1 << p) - 27'd1)) | (27'd1 << p);
         if (r == 3) m = 27'd0;
         if (i % 2 == 1) e = int'($urandom_range(100, 160));
         else e = int'($urandom_range(0, 340)) - 40;
         run_txn(s, e, m, nan, inf, zero, ref_model(s, e, m, nan, inf, zero), 0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
